next_pc_unit: RTL and testbench
===============================

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32, sets the PC and address-path width; bit ADDR_W-1 is the supervisor bit.
REQ-002 Parameter RAS_DEPTH, default 4, sets the return-address-stack entry count (power of two, >=2).
REQ-003 Parameter RST_ADDR, default 0, sets the reset and fallback PC value.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  global clock; all state updates on rising edge.
REQ-006 RESET_N  input  1  asynchronous active-low reset.
REQ-007 stall  input  1  holds all state when high.
REQ-008 PCSEL  input  3  next-PC source select.
REQ-009 JT  input  ADDR_W  jump target.
REQ-010 ShftSextC  input  ADDR_W  branch offset, already scaled by 4.
REQ-011 XAddr, IllOpAddr  input  ADDR_W each  exception and illegal-op vectors.
REQ-012 ras_push  input  1  push PcIncr onto the RAS on this update.
REQ-013 irq  input  1  interrupt request, level or pulse.
REQ-014 pc_o  output  ADDR_W  current PC.
REQ-015 PcIncr  output  ADDR_W  pc_o+4, combinational.
REQ-016 branchOffset  output  ADDR_W  PcIncr+ShftSextC, combinational, modulo 2^ADDR_W.
REQ-017 irq_taken  output  1  one-cycle pulse when an interrupt redirects the PC.
REQ-018 ras_empty  output  1  RAS holds no entries.
REQ-019 ras_count  output  clog2(RAS_DEPTH)+1  number of valid RAS entries.

Function
REQ-020 Update when stall=0: PCSEL 000 -> PcIncr; 001 -> branchOffset; 010 -> {pc[MSB]&JT[MSB], JT[MSB-1:0]}; 011 -> IllOpAddr; 100 -> XAddr; 101 -> RAS pop; 110/111 -> RST_ADDR.
REQ-021 Jump (010) SHALL never set the supervisor bit; it may only clear or keep it.
REQ-022 PCSEL=101 with the RAS non-empty -> pc takes the top entry and count decrements; with the RAS empty -> behaves as 010, count unchanged.
REQ-023 ras_push=1 with a non-pop select -> PcIncr is pushed and count increments; when full, the oldest entry is overwritten and count stays RAS_DEPTH.
REQ-024 ras_push=1 with PCSEL=101 and a non-empty RAS -> pc takes the old top, the top is replaced by PcIncr, count unchanged.
REQ-025 irq SHALL set an internal pending flag on any rising edge of clk where irq=1, stall included.
REQ-026 Interrupt is taken when pending=1, stall=0, pc[MSB]=0 and PCSEL is not 011/100: pc <= XAddr, pending cleared, irq_taken=1 next cycle, ras_push ignored.
REQ-027 PCSEL 011/100 in the same cycle as a takeable interrupt wins; pending is kept.
REQ-028 While pc[MSB]=1, pending is held and not taken.
REQ-029 stall=1 freezes pc, the RAS, ras_count and irq_taken=0; PcIncr and branchOffset still track pc.
REQ-030 All PC arithmetic SHALL wrap modulo 2^ADDR_W with no carry out.
REQ-031 The RAS SHALL be a circular buffer with a top pointer; entries are ADDR_W wide.

Reset
REQ-032 RESET_N=0 SHALL immediately force pc_o=RST_ADDR, ras_count=0, ras_empty=1, pending=0, irq_taken=0, independent of clk.
REQ-033 Reset released mid-stall or mid-interrupt SHALL leave no residual pending or RAS state; first update after release uses normal PCSEL rules.
REQ-034 RAS entry contents need not be cleared at reset; only the pointer and count are.

Verification
REQ-035 Reset, then PCSEL=000 for 3 cycles -> pc_o 0x0, 0x4, 0x8, 0xC.
REQ-036 pc=0x100, ShftSextC=0xFFFFFFF8, PCSEL=001 -> pc_o=0xFC; pc=0x80000010, JT=0x00000040, PCSEL=010 -> pc_o=0x00000040; pc=0x10, JT=0x80000040 -> pc_o=0x00000040.
REQ-037 RAS_DEPTH=4: 5 pushes from pc 0x0,0x10,0x20,0x30,0x40 -> count=4; 4 pops return 0x44,0x34,0x24,0x14; 5th pop with JT=0x200 -> pc_o=0x200, ras_empty=1.
REQ-038 irq pulse during stall=1 at pc=0x20 -> no change; stall drops, PCSEL=000 -> pc_o=XAddr and irq_taken=1 for exactly one cycle.
REQ-039 irq with PCSEL=011 in the same cycle -> pc_o=IllOpAddr (0x80000004); irq held pending while pc[31]=1; after jump to 0x00000100 the next update goes to XAddr.
REQ-040 RESET_N asserted between clock edges with count=3 and pending=1 -> pc_o=RST_ADDR, ras_count=0 and irq_taken=0 without a clock edge.

Source files
------------

// File: rtl/next_pc_unit.sv
// Next-PC selection with a circular return-address stack and a pending-interrupt
// redirect that is only taken from user mode (supervisor bit clear).
module next_pc_unit #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RST_ADDR  = '0
) (
   input  logic                       clk,
   input  logic                       RESET_N,
   input  logic                       stall,
   input  logic [2:0]                 PCSEL,
   input  logic [ADDR_W-1:0]          JT,
   input  logic [ADDR_W-1:0]          ShftSextC,
   input  logic [ADDR_W-1:0]          XAddr,
   input  logic [ADDR_W-1:0]          IllOpAddr,
   input  logic                       ras_push,
   input  logic                       irq,
   output logic [ADDR_W-1:0]          pc_o,
   output logic [ADDR_W-1:0]          PcIncr,
   output logic [ADDR_W-1:0]          branchOffset,
   output logic                       irq_taken,
   output logic                       ras_empty,
   output logic [$clog2(RAS_DEPTH):0] ras_count
);

   localparam int unsigned       PTR_W    = $clog2(RAS_DEPTH);
   localparam int unsigned       CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(3'd4);

   typedef enum logic [2:0] {
      SEL_INCR   = 3'b000,
      SEL_BRANCH = 3'b001,
      SEL_JUMP   = 3'b010,
      SEL_ILLOP  = 3'b011,
      SEL_XCPT   = 3'b100,
      SEL_POP    = 3'b101,
      SEL_RST0   = 3'b110,
      SEL_RST1   = 3'b111
   } pcsel_e;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              pending_q, pending_d;
   logic              irq_taken_q, irq_taken_d;
   logic [PTR_W-1:0]  top_q, top_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

   logic              ras_we_s;
   logic [PTR_W-1:0]  ras_widx_s;
   logic [ADDR_W-1:0] ras_wdata_s;
   logic [ADDR_W-1:0] pc_incr_s;
   logic [ADDR_W-1:0] branch_s;
   logic [ADDR_W-1:0] jump_s;
   logic              ras_nonempty_s;
   logic              pop_s;
   logic              vector_sel_s;
   logic              take_s;

   assign pc_incr_s      = pc_q + PC_STEP;
   assign branch_s       = pc_incr_s + ShftSextC;
   // A jump can keep or drop supervisor mode but never enter it.
   assign jump_s         = {pc_q[ADDR_W-1] & JT[ADDR_W-1], JT[ADDR_W-2:0]};
   assign ras_nonempty_s = (count_q != '0);
   assign pop_s          = (PCSEL == 3'b101) && ras_nonempty_s;
   assign vector_sel_s   = (PCSEL == 3'b011) || (PCSEL == 3'b100);
   assign take_s         = pending_q && !stall && !pc_q[ADDR_W-1] && !vector_sel_s;

   // Next-state for PC, interrupt pending/taken flags and RAS pointer/count.
   always_comb begin
      pc_d        = pc_q;
      pending_d   = irq | pending_q;
      irq_taken_d = 1'b0;
      top_d       = top_q;
      count_d     = count_q;
      ras_we_s    = 1'b0;
      ras_widx_s  = top_q;
      ras_wdata_s = pc_incr_s;
      if (stall) begin
         pc_d = pc_q;
      end else if (take_s) begin
         pc_d        = XAddr;
         pending_d   = irq;
         irq_taken_d = 1'b1;
      end else begin
         case (pcsel_e'(PCSEL))
            SEL_INCR:   pc_d = pc_incr_s;
            SEL_BRANCH: pc_d = branch_s;
            SEL_JUMP:   pc_d = jump_s;
            SEL_ILLOP:  pc_d = IllOpAddr;
            SEL_XCPT:   pc_d = XAddr;
            SEL_POP:    pc_d = ras_nonempty_s ? ras_q[top_q] : jump_s;
            SEL_RST0:   pc_d = RST_ADDR;
            SEL_RST1:   pc_d = RST_ADDR;
            default:    pc_d = RST_ADDR;
         endcase
         if (pop_s && ras_push) begin
            ras_we_s   = 1'b1;
            ras_widx_s = top_q;
         end else if (pop_s) begin
            top_d   = top_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
         end else if (ras_push) begin
            // Advancing onto the oldest slot when full overwrites it.
            ras_we_s   = 1'b1;
            ras_widx_s = top_q + PTR_ONE;
            top_d      = top_q + PTR_ONE;
            count_d    = (count_q == CNT_FULL) ? count_q : count_q + CNT_ONE;
         end else begin
            top_d = top_q;
         end
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         pc_q        <= RST_ADDR;
         pending_q   <= 1'b0;
         irq_taken_q <= 1'b0;
         top_q       <= '0;
         count_q     <= '0;
      end else begin
         pc_q        <= pc_d;
         pending_q   <= pending_d;
         irq_taken_q <= irq_taken_d;
         top_q       <= top_d;
         count_q     <= count_d;
      end
   end

   // RAS storage; contents are qualified by count, so they carry no reset.
   always_ff @(posedge clk) begin
      if (ras_we_s) begin
         ras_q[ras_widx_s] <= ras_wdata_s;
      end
   end

   assign pc_o         = pc_q;
   assign PcIncr       = pc_incr_s;
   assign branchOffset = branch_s;
   assign irq_taken    = irq_taken_q;
   assign ras_empty    = (count_q == '0);
   assign ras_count    = count_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed and randomized checks of next_pc_unit against a queue-based reference model.
module tb_next_pc_unit;

   logic        clk = 1'b0;
   logic        RESET_N = 1'b0;
   logic        stall = 1'b0;
   logic [2:0]  PCSEL = 3'd0;
   logic [31:0] JT = 32'd0, ShftSextC = 32'd0, XAddr = 32'd0, IllOpAddr = 32'd0;
   logic        ras_push = 1'b0;
   logic        irq = 1'b0;
   logic [31:0] pc_o, PcIncr, branchOffset;
   logic        irq_taken, ras_empty;
   logic [2:0]  ras_count;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_pc = 32'd0;
   bit          m_pend = 1'b0;
   bit          m_taken = 1'b0;
   logic [31:0] m_ras [$];

   next_pc_unit dut (
      .clk(clk), .RESET_N(RESET_N), .stall(stall), .PCSEL(PCSEL), .JT(JT),
      .ShftSextC(ShftSextC), .XAddr(XAddr), .IllOpAddr(IllOpAddr),
      .ras_push(ras_push), .irq(irq), .pc_o(pc_o), .PcIncr(PcIncr),
      .branchOffset(branchOffset), .irq_taken(irq_taken),
      .ras_empty(ras_empty), .ras_count(ras_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("pc_o", pc_o, m_pc);
      check("ras_count", {29'd0, ras_count}, 32'(m_ras.size()));
      check("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
      check("irq_taken", {31'd0, irq_taken}, {31'd0, m_taken});
      check("PcIncr", PcIncr, m_pc + 32'd4);
      check("branchOffset", branchOffset, m_pc + 32'd4 + ShftSextC);
   endtask

   // One clock edge: advance the model from the current inputs, then compare.
   task automatic tick();
      logic [31:0] incr, nxt;
      bit take;
      incr = m_pc + 32'd4;
      nxt  = m_pc;
      take = m_pend && !stall && !m_pc[31] && !(PCSEL == 3'd3 || PCSEL == 3'd4);
      if (stall) begin
         m_taken = 1'b0;
      end else if (take) begin
         nxt = XAddr;
         m_taken = 1'b1;
      end else begin
         m_taken = 1'b0;
         if (PCSEL == 3'd5 && m_ras.size() != 0) begin
            nxt = m_ras[m_ras.size()-1];
            if (ras_push) m_ras[m_ras.size()-1] = incr;
            else void'(m_ras.pop_back());
         end else begin
            case (PCSEL)
               3'd0: nxt = incr;
               3'd1: nxt = incr + ShftSextC;
               3'd2, 3'd5: nxt = {m_pc[31] & JT[31], JT[30:0]};
               3'd3: nxt = IllOpAddr;
               3'd4: nxt = XAddr;
               default: nxt = 32'd0;
            endcase
            if (ras_push) begin
               m_ras.push_back(incr);
               if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
         end
      end
      m_pc = nxt;
      m_pend = irq || (m_pend && !take);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_in(input logic [2:0] sel, input logic [31:0] jt, input bit push,
                         input bit st, input bit rq);
      PCSEL = sel; JT = jt; ras_push = push; stall = st; irq = rq;
   endtask

   // Assert reset between edges and check the outputs without a clock edge.
   task automatic do_reset();
      #2 RESET_N = 1'b0;
      #1;
      m_pc = 32'd0; m_pend = 1'b0; m_taken = 1'b0; m_ras.delete();
      check("rst_pc", pc_o, 32'd0);
      check("rst_count", {29'd0, ras_count}, 32'd0);
      check("rst_empty", {31'd0, ras_empty}, 32'd1);
      check("rst_taken", {31'd0, irq_taken}, 32'd0);
      #2 RESET_N = 1'b1;
   endtask

   initial begin
      // Initial reset and sequential fetch
      #1;
      check("por_pc", pc_o, 32'd0);
      check("por_empty", {31'd0, ras_empty}, 32'd1);
      #2 RESET_N = 1'b1;
      set_in(3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      tick(); check("seq1", pc_o, 32'h4);
      tick(); check("seq2", pc_o, 32'h8);
      tick(); check("seq3", pc_o, 32'hC);

      // Branch backward and supervisor-bit jump rules
      set_in(3'd2, 32'h100, 1'b0, 1'b0, 1'b0); tick();
      ShftSextC = 32'hFFFF_FFF8; PCSEL = 3'd1; tick();
      check("branch_back", pc_o, 32'hFC);
      ShftSextC = 32'd0;
      IllOpAddr = 32'h8000_0010; PCSEL = 3'd3; tick();
      set_in(3'd2, 32'h0000_0040, 1'b0, 1'b0, 1'b0); tick();
      check("jump_clr_sup", pc_o, 32'h40);
      set_in(3'd2, 32'h10, 1'b0, 1'b0, 1'b0); tick();
      set_in(3'd2, 32'h8000_0040, 1'b0, 1'b0, 1'b0); tick();
      check("jump_no_set_sup", pc_o, 32'h40);

      // RAS overflow then drain
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         set_in(3'd2, (i == 5) ? 32'h100 : 32'(i * 16), 1'b1, 1'b0, 1'b0);
         tick();
      end
      check("ras_full", {29'd0, ras_count}, 32'd4);
      for (int i = 0; i < 4; i++) begin
         set_in(3'd5, 32'h200, 1'b0, 1'b0, 1'b0); tick();
         check("ras_pop", pc_o, 32'h44 - 32'(i * 16));
      end
      tick();
      check("pop_empty_jump", pc_o, 32'h200);
      check("pop_empty_flag", {31'd0, ras_empty}, 32'd1);

      // Interrupt raised during stall
      XAddr = 32'h0000_0800;
      set_in(3'd2, 32'h20, 1'b0, 1'b0, 1'b0); tick();
      set_in(3'd0, 32'h0, 1'b0, 1'b1, 1'b1); tick();
      check("stall_hold", pc_o, 32'h20);
      set_in(3'd0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
      set_in(3'd0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
      check("irq_vector", pc_o, 32'h800);
      check("irq_pulse", {31'd0, irq_taken}, 32'd1);
      tick();
      check("irq_pulse_end", {31'd0, irq_taken}, 32'd0);

      // Illegal-op beats interrupt, pending held in supervisor mode
      XAddr = 32'h0000_1000; IllOpAddr = 32'h8000_0004;
      set_in(3'd3, 32'h0, 1'b0, 1'b0, 1'b1); tick();
      check("illop_wins", pc_o, 32'h8000_0004);
      set_in(3'd0, 32'h0, 1'b0, 1'b0, 1'b0); tick(); tick();
      set_in(3'd2, 32'h100, 1'b0, 1'b0, 1'b0); tick();
      check("sup_exit", pc_o, 32'h100);
      set_in(3'd0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
      check("deferred_irq", pc_o, 32'h1000);

      // Reset between edges with RAS and pending state live
      for (int i = 0; i < 3; i++) begin
         set_in(3'd0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
      end
      set_in(3'd0, 32'h0, 1'b0, 1'b1, 1'b1); tick();
      check("pre_rst_count", {29'd0, ras_count}, 32'd3);
      do_reset();
      set_in(3'd0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
      check("post_rst_seq", pc_o, 32'h4);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         PCSEL     = 3'($urandom_range(0, 7));
         JT        = $urandom;
         ShftSextC = $urandom & 32'hFFFF_FFFC;
         XAddr     = $urandom;
         IllOpAddr = $urandom;
         ras_push  = ($urandom_range(0, 2) == 0);
         stall     = ($urandom_range(0, 4) == 0);
         irq       = ($urandom_range(0, 7) == 0);
         tick();
         if ($urandom_range(0, 96) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
